uart_message_loader: RTL
========================

# uart_message_loader

Receives a hex-character message over a UART line and assembles it into the 16-character, 4-bit-per-character message bus consumed by the scrolling-text stage. It sits upstream of the scroller and replaces the fixed memory initialisation with a runtime-loadable buffer. It runs on the divided 5 MHz system clock. It double-buffers the message: a shadow buffer fills during reception, and the output bus updates atomically on commit.

## Interface
- `CLKS_PER_BIT`, default 43: clock cycles per UART bit (5 MHz / 115200 baud). Legal values are ≥ 4.
- `clk`, input, 1: system clock (divided 5 MHz clock).
- `reset`, input, 1: synchronous, active-high reset.
- `rx`, input, 1: asynchronous UART line, idle high.
- `message`, output, 64: committed message. `message[4*i+3:4*i]` is character i; character 15 is shown first.
- `msg_valid`, output, 1: one-cycle pulse when `message` updates.
- `char_count`, output, 5: number of characters currently in the shadow buffer (0–16).
- `frame_err`, output, 1: sticky; a stop bit was sampled low.
- `char_err`, output, 1: sticky; a non-hex byte was received.
- `parity_err`, output, 1: sticky; present only with `LOADER_PARITY_EN`, otherwise tied to 0.

## Operation
- Clock is a single `clk`. Reset is synchronous and active-high.
- **Reset values:**
  - `message` = 64'h0123_4567_89AB_CDEF.
  - `msg_valid` = 0, `char_count` = 0.
  - All error flags = 0.
  - Shadow buffer = 0.
  - FSM = IDLE.
- **Synchroniser:** 2-flop synchroniser on `rx`; all logic uses the synchronised value.
- **Receive FSM:**
  - IDLE → START on synchronised `rx` = 0.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then resample. Low → DATA; high → IDLE (glitch rejected, no error).
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first. → PARITY if the macro is defined, else → STOP.
  - PARITY: one more sample, then → STOP.
  - STOP: sample one bit period later.
    - High → byte accepted, → IDLE.
    - Low → `frame_err` set, byte dropped, → WAIT_HIGH.
  - WAIT_HIGH: stay until synchronised `rx` = 1, then → IDLE.
- **Byte decode (accepted bytes only):**
  - 0x30–0x39 → char code 0–9.
  - 0x41–0x46 and 0x61–0x66 → char code 10–15.
  - 0x0D (CR) → commit request.
  - 0x0A (LF) → ignored, no error.
  - Any other byte → `char_err` set, byte dropped.
- **Shadow write:**
  - Character k (0-based, in arrival order) is written to shadow slot 15−k.
  - `char_count` increments by 1 per character.
- **Commit:**
  - Triggers: a CR received with `char_count` > 0, or the 16th character written.
  - `message` ← shadow, with unfilled slots = 0.
  - `msg_valid` pulses high.
  - Shadow cleared, `char_count` ← 0.
- **CR with `char_count` = 0:** ignored; no pulse, no change to `message`.
- **Auto-commit then CR:** a CR right after a 16-character auto-commit is therefore a no-op.
- **Error flags:** sticky until reset. Errors never block later bytes.

## Timing
- Start-edge latency: 2 cycles from the `rx` pin to the FSM (synchroniser).
- Commit latency: the byte is accepted on the stop-bit sample cycle (S). Decode and shadow write happen in cycle S+1. Commit registers `message`, `msg_valid`, and clears `char_count` at the end of cycle S+1, so they are visible from S+2 for exactly one cycle (`msg_valid`).
- Error flags rise on the cycle after the offending sample.
- Minimum frame length: 10 bit periods (11 with parity). Back-to-back frames with no idle bits are accepted.
- Reset mid-frame: the partial byte is discarded, the FSM goes to IDLE, and everything returns to reset values on the next edge.
- Reset has priority over commit in the same cycle.

## Configuration
- **`LOADER_PARITY_EN`** defined:
  - Frame is 8E1. An even-parity bit follows D7.
  - On mismatch, `parity_err` is set and the byte is dropped. The stop bit is still checked.
- **`LOADER_PARITY_EN`** undefined:
  - Frame is 8N1.
  - No PARITY state.
  - `parity_err` is a constant 0.

## Test plan
Run with `CLKS_PER_BIT` = 8.
- **Reset check:** reset, then idle.
  - `message` = 64'h0123456789ABCDEF, `msg_valid` = 0, `char_count` = 0.
- **Short line with CR:** send "A5f", then CR.
  - One `msg_valid` pulse; `message` = 64'hA5F0_0000_0000_0000; `char_count` → 0.
- **16-character auto-commit:** send "FEDCBA9876543210", then CR.
  - `msg_valid` pulses after the 16th character; `message` = 64'hFEDCBA9876543210.
  - The CR produces no pulse.
- **Errors:**
  - Send 'G' (0x47) → `char_err` = 1, `char_count` unchanged.
  - Send a frame with the stop bit forced low → `frame_err` = 1.
  - Then send "1" + CR → `message` = 64'h1000_0000_0000_0000.
- **Glitch and reset mid-frame:**
  - 3-cycle low pulse on `rx` → no byte, no error.
  - Assert reset during D4 of a '7' frame → `char_count` = 0, `message` = reset value, no pulse.
- **Parity (with `LOADER_PARITY_EN`):**
  - Send '3' (0x33, 4 ones) with parity bit 1 → `parity_err` = 1, `char_count` = 0.
  - With parity bit 0 → `char_count` = 1.

Source files
------------

// File: rtl/uart_message_loader.sv
// rtl/uart_message_loader.sv - UART hex-character receiver feeding a double-buffered 16-char message bus
// Optional build macro LOADER_PARITY_EN selects 8E1 framing and enables the sticky parity_err flag.
module uart_message_loader #(
    parameter int CLKS_PER_BIT = 43
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [63:0] message,
    output logic        msg_valid,
    output logic [4:0]  char_count,
    output logic        frame_err,
    output logic        char_err,
    output logic        parity_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [63:0]   MSG_RESET = 64'h0123_4567_89AB_CDEF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef LOADER_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t         state_q, state_d;
    logic           rx_meta_q, rx_sync_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     byte_q, byte_d;
    logic           byte_vld_q, byte_vld_d;
    logic           frame_err_q, frame_err_d;
    logic           char_err_q, char_err_d;
    logic [63:0]    shadow_q, shadow_d;
    logic [63:0]    message_q, message_d;
    logic           msg_valid_q, msg_valid_d;
    logic [4:0]     count_q, count_d;
`ifdef LOADER_PARITY_EN
    logic           par_bad_q, par_bad_d;
    logic           parity_err_q, parity_err_d;
`endif

    logic           is_hex;
    logic [3:0]     code;
    logic [3:0]     slot;
    logic [63:0]    written;

    // Receive framing: every sample lands mid-bit, counted from the half-bit point of the start bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        frame_err_d = frame_err_q;
`ifdef LOADER_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef LOADER_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx_sync_q ^ (^shift_q);
                    if (rx_sync_q ^ (^shift_q)) parity_err_d = 1'b1;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_d  = shift_q;
`ifdef LOADER_PARITY_EN
                        byte_vld_d = !par_bad_q;
`else
                        byte_vld_d = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_sync_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_hex = 1'b0;
        code   = 4'd0;
        if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
            is_hex = 1'b1;
            code   = byte_q[3:0];
        end else if ((byte_q >= 8'h41 && byte_q <= 8'h46) ||
                     (byte_q >= 8'h61 && byte_q <= 8'h66)) begin
            is_hex = 1'b1;
            code   = byte_q[3:0] + 4'd9;
        end
    end

    // Shadow fill and commit; the 16th character commits the buffer including itself.
    always_comb begin
        shadow_d    = shadow_q;
        count_d     = count_q;
        message_d   = message_q;
        msg_valid_d = 1'b0;
        char_err_d  = char_err_q;
        slot        = 4'd15 - count_q[3:0];
        written     = shadow_q;
        written[{slot, 2'b00} +: 4] = code;
        if (byte_vld_q) begin
            if (is_hex) begin
                if (count_q == 5'd15) begin
                    message_d   = written;
                    msg_valid_d = 1'b1;
                    shadow_d    = '0;
                    count_d     = '0;
                end else begin
                    shadow_d = written;
                    count_d  = count_q + 5'd1;
                end
            end else if (byte_q == 8'h0D) begin
                if (count_q != 5'd0) begin
                    message_d   = shadow_q;
                    msg_valid_d = 1'b1;
                    shadow_d    = '0;
                    count_d     = '0;
                end
            end else if (byte_q != 8'h0A) begin
                char_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            char_err_q  <= 1'b0;
            shadow_q    <= '0;
            message_q   <= MSG_RESET;
            msg_valid_q <= 1'b0;
            count_q     <= '0;
`ifdef LOADER_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            frame_err_q <= frame_err_d;
            char_err_q  <= char_err_d;
            shadow_q    <= shadow_d;
            message_q   <= message_d;
            msg_valid_q <= msg_valid_d;
            count_q     <= count_d;
`ifdef LOADER_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign message    = message_q;
    assign msg_valid  = msg_valid_q;
    assign char_count = count_q;
    assign frame_err  = frame_err_q;
    assign char_err   = char_err_q;
`ifdef LOADER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
